// File: rtl/pipe_datapath_if.sv
// Decode-field / result bundle between the external controller (master) and pipe_datapath (slave).
interface pipe_datapath_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int IMMW  = 8,
  parameter int PCW   = 16
);
  localparam int RW = $clog2(NREG);

  logic             stall;
  logic             validD;
  logic [RW-1:0]    raD, rbD, rdD;
  logic [IMMW-1:0]  immD;
  logic             alusrcD;
  logic [3:0]       aluctlD;
  logic             regwriteD;
  logic [1:0]       brtypeD;
  logic [PCW-1:0]   pc;
  logic             redirect;
  logic [WIDTH-1:0] aluoutE;
  logic             S, Z, C, V;
  logic             wbvalid;
  logic [RW-1:0]    wbaddr;
  logic [WIDTH-1:0] wbdata;

  modport master (
    output stall, validD, raD, rbD, rdD, immD, alusrcD, aluctlD, regwriteD, brtypeD,
    input  pc, redirect, aluoutE, S, Z, C, V, wbvalid, wbaddr, wbdata
  );

  modport slave (
    input  stall, validD, raD, rbD, rdD, immD, alusrcD, aluctlD, regwriteD, brtypeD,
    output pc, redirect, aluoutE, S, Z, C, V, wbvalid, wbaddr, wbdata
  );
endinterface

// File: rtl/pipe_datapath.sv
// Three-stage (decode/execute/writeback) datapath: regfile with write-through,
// WB->EX forwarding, ALU with registered SZCV flags, branch redirect with one-slot flush.
module pipe_datapath #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int IMMW  = 8,
  parameter int PCW   = 16
) (
  input  logic           clk,
  input  logic           reset,
  pipe_datapath_if.slave bus
);
  localparam int RW  = $clog2(NREG);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_MOV = 4'd8;

  typedef struct packed {
    logic             valid;
    logic [PCW-1:0]   pc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [IMMW-1:0]  imm;
    logic [RW-1:0]    ra;
    logic [RW-1:0]    rb;
    logic [RW-1:0]    rd;
    logic             alusrc;
    logic [3:0]       aluctl;
    logic             regwrite;
    logic [1:0]       brtype;
  } idEx_t;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic [RW-1:0]    rd;
    logic [WIDTH-1:0] data;
  } exWb_t;

  idEx_t                      idEx;
  exWb_t                      exWb;
  logic [NREG-1:0][WIDTH-1:0] rf;
  logic [PCW-1:0]             pc;
  logic                       flgS, flgZ, flgC, flgV;

  logic             wbValid, issue, taken, redirect, flagOp, cOut, vOut;
  logic [WIDTH-1:0] rdA, rdB, srcA, fwdB, srcB, immE, aluOut;
  logic [WIDTH:0]   ext;
  logic [SHW-1:0]   sh;
  logic [PCW-1:0]   target;

  assign wbValid = exWb.valid & exWb.regwrite;

  // Decode read: a same-cycle WB write to the address wins over the array
  assign rdA   = (wbValid && exWb.rd == bus.raD) ? exWb.data : rf[bus.raD];
  assign rdB   = (wbValid && exWb.rd == bus.rbD) ? exWb.data : rf[bus.rbD];
  assign issue = bus.validD & ~bus.stall & ~redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idEx <= '0;
    else begin
      idEx.valid <= issue;
      if (issue) begin
        idEx.pc       <= pc;
        idEx.a        <= rdA;
        idEx.b        <= rdB;
        idEx.imm      <= bus.immD;
        idEx.ra       <= bus.raD;
        idEx.rb       <= bus.rbD;
        idEx.rd       <= bus.rdD;
        idEx.alusrc   <= bus.alusrcD;
        idEx.aluctl   <= bus.aluctlD;
        idEx.regwrite <= bus.regwriteD;
        idEx.brtype   <= bus.brtypeD;
      end
    end
  end

  // EX operands: the instruction in WB is one older and may not be in the ID/EX copy yet
  assign immE = WIDTH'($signed(idEx.imm));
  assign srcA = (wbValid && exWb.rd == idEx.ra) ? exWb.data : idEx.a;
  assign fwdB = (wbValid && exWb.rd == idEx.rb) ? exWb.data : idEx.b;
  assign srcB = idEx.alusrc ? immE : fwdB;
  assign sh   = srcB[SHW-1:0];

  always_comb begin
    ext    = '0;
    aluOut = '0;
    cOut   = 1'b0;
    vOut   = 1'b0;
    flagOp = 1'b1;
    case (idEx.aluctl)
      OP_ADD: begin
        ext    = {1'b0, srcA} + {1'b0, srcB};
        aluOut = ext[MSB:0];
        cOut   = ext[WIDTH];
        vOut   = (srcA[MSB] == srcB[MSB]) && (aluOut[MSB] != srcA[MSB]);
      end
      OP_SUB: begin
        ext    = {1'b0, srcA} + {1'b0, ~srcB} + (WIDTH+1)'(1);
        aluOut = ext[MSB:0];
        cOut   = ext[WIDTH];
        vOut   = (srcA[MSB] != srcB[MSB]) && (aluOut[MSB] != srcA[MSB]);
      end
      OP_AND: aluOut = srcA & srcB;
      OP_OR:  aluOut = srcA | srcB;
      OP_XOR: aluOut = srcA ^ srcB;
      // Shifts run one bit wider so the last bit shifted out lands in the spare bit
      OP_SLL: begin
        ext    = {1'b0, srcA} << sh;
        aluOut = ext[MSB:0];
        cOut   = ext[WIDTH];
      end
      OP_SRL: begin
        ext    = {srcA, 1'b0} >> sh;
        aluOut = ext[WIDTH:1];
        cOut   = ext[0];
      end
      OP_SRA: begin
        ext    = $signed({srcA, 1'b0}) >>> sh;
        aluOut = ext[WIDTH:1];
        cOut   = ext[0];
      end
      OP_MOV: aluOut = srcB;
      default: flagOp = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (idEx.brtype)
      2'd1:    taken = 1'b1;
      2'd2:    taken = flgZ;
      2'd3:    taken = flgS;
      default: taken = 1'b0;
    endcase
  end

  assign redirect = idEx.valid & taken;
  assign target   = idEx.pc + PCW'(1) + PCW'($signed(idEx.imm));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             pc <= '0;
    else if (redirect)      pc <= target;
    else if (!bus.stall)    pc <= pc + PCW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {flgS, flgZ, flgC, flgV} <= '0;
    else if (idEx.valid && flagOp && idEx.brtype == 2'd0)
      {flgS, flgZ, flgC, flgV} <= {aluOut[MSB], aluOut == '0, cOut, vOut};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) exWb <= '0;
    else begin
      exWb.valid    <= idEx.valid;
      exWb.regwrite <= idEx.regwrite;
      exWb.rd       <= idEx.rd;
      exWb.data     <= aluOut;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       rf <= '0;
    else if (wbValid) rf[exWb.rd] <= exWb.data;
  end

  assign bus.pc       = pc;
  assign bus.redirect = redirect;
  assign bus.aluoutE  = aluOut;
  assign bus.S        = flgS;
  assign bus.Z        = flgZ;
  assign bus.C        = flgC;
  assign bus.V        = flgV;
  assign bus.wbvalid  = wbValid;
  assign bus.wbaddr   = exWb.rd;
  assign bus.wbdata   = exWb.data;
endmodule

// File: tb/tb_pipe_datapath.sv
// Bench for pipe_datapath: ALU vector table, directed pipeline sequences and random
// traffic, all cross-checked every cycle against an in-order instruction-level model.
module tb_pipe_datapath;
  localparam int WIDTH = 16, NREG = 8, IMMW = 8, PCW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  pipe_datapath_if #(.WIDTH(WIDTH), .NREG(NREG), .IMMW(IMMW), .PCW(PCW)) bus();
  pipe_datapath #(.WIDTH(WIDTH), .NREG(NREG), .IMMW(IMMW), .PCW(PCW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid, stall;
    logic [2:0] ra, rb, rd;
    logic [7:0] imm;
    logic       alusrc;
    logic [3:0] ctl;
    logic       rw;
    logic [1:0] br;
  } dec_t;

  typedef struct {
    bit       present, we, upd;
    int       addr, data;
    bit [3:0] flg;             // {S,Z,C,V}
  } slot_t;

  typedef struct {
    int       op, a, b, out;
    bit [3:0] flg;
  } vec_t;

  int       nChk = 0, nPass = 0;
  int       mRf[NREG];
  bit [3:0] archFlg, visFlg;
  int       mPc, mTarget;
  bit       mRedir;
  slot_t    exS, wbS;
  vec_t     tbl[16];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic int sx8(logic [7:0] i);
    return i[7] ? int'(i) - 256 : int'(i);
  endfunction

  function automatic dec_t ins(int ctl, int rd, int ra, int rb, bit src, int imm,
                               bit rw = 1'b1, int br = 0);
    dec_t d;
    d.valid = 1'b1; d.stall = 1'b0;
    d.ctl = 4'(ctl); d.rd = 3'(rd); d.ra = 3'(ra); d.rb = 3'(rb);
    d.alusrc = src; d.imm = 8'(imm); d.rw = rw; d.br = 2'(br);
    return d;
  endfunction

  function automatic dec_t nop();
    dec_t d;
    d = ins(0, 0, 0, 0, 1'b0, 0, 1'b0, 0);
    d.valid = 1'b0;
    return d;
  endfunction

  // Instruction-level meaning of each ALU op on 16-bit unsigned values
  function automatic void refAlu(input int op, input int a, input int b,
                                 output int res, output bit [3:0] flg, output bit upd);
    int sa, sb, sh, t;
    bit c, v;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    sh = b % 16;
    c = 1'b0; v = 1'b0; upd = 1'b1; res = 0;
    case (op)
      0: begin t = a + b; res = t % 65536; c = (t >= 65536);
               v = (sa + sb > 32767) || (sa + sb < -32768); end
      1: begin t = a + (65535 - b) + 1; res = t % 65536; c = (t >= 65536);
               v = (sa - sb > 32767) || (sa - sb < -32768); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a << sh) % 65536; c = (sh != 0) && (((a >> (16 - sh)) & 1) == 1); end
      6: begin res = a >> sh;           c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
      7: begin res = (sa >>> sh) & 65535; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
      8: res = b;
      default: upd = 1'b0;
    endcase
    flg = {res >= 32768, res == 0, c, v};
  endfunction

  task automatic drive(input dec_t d);
    bus.validD = d.valid; bus.stall = d.stall;
    bus.raD = d.ra; bus.rbD = d.rb; bus.rdD = d.rd; bus.immD = d.imm;
    bus.alusrcD = d.alusrc; bus.aluctlD = d.ctl; bus.regwriteD = d.rw; bus.brtypeD = d.br;
  endtask

  task automatic modelClear();
    foreach (mRf[i]) mRf[i] = 0;
    archFlg = '0; visFlg = '0; mPc = 0; mTarget = 0; mRedir = 1'b0;
    exS = '{default: 0}; wbS = '{default: 0};
  endtask

  // One clock: drive decode, check the current cycle against the model at negedge,
  // advance the model, return 1 time unit after the next rising edge.
  task automatic step(input dec_t d);
    bit issue, taken, upd;
    int a, b, res;
    bit [3:0] flg;
    slot_t nx;
    drive(d);
    @(negedge clk);
    chk("pc", 32'(bus.pc), mPc);
    chk("redirect", 32'(bus.redirect), 32'(mRedir));
    chk("wbvalid", 32'(bus.wbvalid), 32'(wbS.present && wbS.we));
    if (wbS.present && wbS.we) begin
      chk("wbaddr", 32'(bus.wbaddr), wbS.addr);
      chk("wbdata", 32'(bus.wbdata), wbS.data);
    end
    chk("flags", 32'({bus.S, bus.Z, bus.C, bus.V}), 32'(visFlg));
    if (exS.present) chk("aluoutE", 32'(bus.aluoutE), exS.data);

    nx = '{default: 0};
    taken = 1'b0;
    issue = d.valid && !d.stall && !mRedir;
    if (issue) begin
      a = mRf[d.ra];
      b = d.alusrc ? (sx8(d.imm) + 65536) % 65536 : mRf[d.rb];
      refAlu(int'(d.ctl), a, b, res, flg, upd);
      upd = upd && (d.br == 2'd0);
      case (d.br)
        2'd1: taken = 1'b1;
        2'd2: taken = archFlg[2];
        2'd3: taken = archFlg[3];
        default: taken = 1'b0;
      endcase
      if (upd) archFlg = flg;
      if (d.rw) mRf[d.rd] = res;
      nx.present = 1'b1; nx.we = d.rw; nx.upd = upd;
      nx.addr = int'(d.rd); nx.data = res; nx.flg = flg;
      if (taken) mTarget = (mPc + 1 + sx8(d.imm) + 65536) % 65536;
    end
    if (mRedir)        mPc = mTarget;
    else if (!d.stall) mPc = (mPc + 1) % 65536;
    if (exS.present && exS.upd) visFlg = exS.flg;
    wbS = exS;
    exS = nx;
    mRedir = taken;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    drive(nop());
    modelClear();
    #2;
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_wbvalid", 32'(bus.wbvalid), 0);
    chk("rst_redirect", 32'(bus.redirect), 0);
    chk("rst_flags", 32'({bus.S, bus.Z, bus.C, bus.V}), 0);
    chk("rst_aluoutE", 32'(bus.aluoutE), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Build an arbitrary 16-bit value from 8-bit sign-extended immediates; r6 is scratch
  task automatic loadReg(input int r, input int v);
    step(ins(8, r, 0, 0, 1'b1, (v >> 8) & 255));
    step(ins(5, r, r, 0, 1'b1, 8));
    step(ins(8, 6, 0, 0, 1'b1, v & 255));
    step(ins(5, 6, 6, 0, 1'b1, 8));
    step(ins(6, 6, 6, 0, 1'b1, 8));
    step(ins(3, r, r, 6, 1'b0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    dec_t d;
    int p;
    tbl[0]  = '{0, 'h7FFF, 'h0001, 'h8000, 4'b1001};
    tbl[1]  = '{1, 'h0000, 'h0001, 'hFFFF, 4'b1000};
    tbl[2]  = '{1, 'h0005, 'h0005, 'h0000, 4'b0110};
    tbl[3]  = '{0, 'hFFFF, 'h0001, 'h0000, 4'b0110};
    tbl[4]  = '{2, 'hF0F0, 'h0FF0, 'h00F0, 4'b0000};
    tbl[5]  = '{3, 'hF000, 'h000F, 'hF00F, 4'b1000};
    tbl[6]  = '{4, 'hFFFF, 'h00FF, 'hFF00, 4'b1000};
    tbl[7]  = '{5, 'h8001, 'h0001, 'h0002, 4'b0010};
    tbl[8]  = '{6, 'h8001, 'h0001, 'h4000, 4'b0010};
    tbl[9]  = '{7, 'h8000, 'h0004, 'hF800, 4'b1000};
    tbl[10] = '{7, 'h8008, 'h0004, 'hF800, 4'b1010};
    tbl[11] = '{5, 'h1234, 'h0000, 'h1234, 4'b0000};
    tbl[12] = '{5, 'h0001, 'h0011, 'h0002, 4'b0000};
    tbl[13] = '{8, 'h1234, 'h0000, 'h0000, 4'b0100};
    tbl[14] = '{1, 'h8000, 'h0001, 'h7FFF, 4'b0011};
    tbl[15] = '{9, 'h1234, 'h0005, 'h0000, 4'b0000};  // flags stay from loading r2=5

    doReset();
    for (int k = 1; k <= 3; k++) begin
      step(nop());
      chk($sformatf("freerun_pc%0d", k), 32'(bus.pc), k);
      chk("freerun_wbvalid", 32'(bus.wbvalid), 0);
    end

    // MOV r1<-5 then ADD r2=r1+r1 through EX forwarding
    step(ins(8, 1, 0, 0, 1'b1, 5));
    step(ins(0, 2, 1, 1, 1'b0, 0));
    step(nop());
    chk("fwd_wbvalid", 32'(bus.wbvalid), 1);
    chk("fwd_wbaddr", 32'(bus.wbaddr), 2);
    chk("fwd_wbdata", 32'(bus.wbdata), 10);
    chk("fwd_Z", 32'(bus.Z), 0);

    foreach (tbl[i]) begin
      loadReg(1, tbl[i].a);
      loadReg(2, tbl[i].b);
      step(ins(tbl[i].op, 3, 1, 2, 1'b0, 0));
      chk($sformatf("tbl%0d_aluoutE", i), 32'(bus.aluoutE), tbl[i].out);
      step(nop());
      chk($sformatf("tbl%0d_wbdata", i), 32'(bus.wbdata), tbl[i].out);
      chk($sformatf("tbl%0d_flags", i), 32'({bus.S, bus.Z, bus.C, bus.V}), 32'(tbl[i].flg));
    end

    // SUB to zero at pc 8, branch-if-Z imm -3 at pc 10 -> target 8, next slot flushed
    doReset();
    for (int k = 0; k < 8; k++) step(nop());
    step(ins(1, 3, 0, 0, 1'b0, 0));
    step(nop());
    step(ins(0, 0, 0, 0, 1'b1, 'hFD, 1'b0, 2));
    chk("br_redirect", 32'(bus.redirect), 1);
    step(ins(8, 5, 0, 0, 1'b1, 7));
    chk("br_pc", 32'(bus.pc), 8);
    chk("br_redirect_drop", 32'(bus.redirect), 0);
    step(nop());
    chk("br_flush_nowrite", 32'(bus.wbvalid), 0);
    step(ins(0, 5, 5, 0, 1'b1, 0));
    step(nop());
    chk("br_r5_untouched", 32'(bus.wbdata), 0);

    // Two stalled cycles with a pending instruction
    step(nop());
    step(nop());
    p = mPc;
    d = ins(8, 4, 0, 0, 1'b1, 'h33);
    d.stall = 1'b1;
    step(d);
    chk("stall_pc1", 32'(bus.pc), p);
    step(d);
    chk("stall_pc2", 32'(bus.pc), p);
    chk("stall_bubble1", 32'(bus.wbvalid), 0);
    d.stall = 1'b0;
    step(d);
    chk("stall_pc3", 32'(bus.pc), p + 1);
    chk("stall_bubble2", 32'(bus.wbvalid), 0);
    step(nop());
    chk("stall_issue_wbvalid", 32'(bus.wbvalid), 1);
    chk("stall_issue_wbaddr", 32'(bus.wbaddr), 4);
    chk("stall_issue_wbdata", 32'(bus.wbdata), 'h33);

    // Reset with writes in EX and WB; every register must then read 0
    step(ins(8, 1, 0, 0, 1'b1, 3));
    step(ins(8, 2, 0, 0, 1'b1, 4));
    doReset();
    for (int r = 0; r < NREG; r++) begin
      step(ins(0, r, r, 0, 1'b1, 0));
      step(nop());
      chk($sformatf("rst_r%0d_wbaddr", r), 32'(bus.wbaddr), r);
      chk($sformatf("rst_r%0d_wbdata", r), 32'(bus.wbdata), 0);
    end

    // Random traffic against the model, with one reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) doReset();
      d.valid  = ($urandom_range(0, 9) < 8);
      d.stall  = ($urandom_range(0, 7) == 0);
      d.ra     = 3'($urandom_range(0, 7));
      d.rb     = 3'($urandom_range(0, 7));
      d.rd     = 3'($urandom_range(0, 7));
      d.imm    = 8'($urandom_range(0, 255));
      d.alusrc = 1'($urandom_range(0, 1));
      d.ctl    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      d.rw     = 1'($urandom_range(0, 1));
      d.br     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      step(d);
    end
    step(nop());
    step(nop());

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
